// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side instruction fields, MEM/WB bypass sources and the
// registered ALU-side fields, with slave (stage) and master (driver) views.
interface id_ex_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FUNC_WIDTH = 5,
    parameter int REG_AW     = 5
);
    logic                  id_valid;
    logic                  id_ready;
    logic                  flush;
    logic [DATA_WIDTH-1:0] id_pc;
    logic [DATA_WIDTH-1:0] id_rs1_data;
    logic [DATA_WIDTH-1:0] id_rs2_data;
    logic [DATA_WIDTH-1:0] id_imm;
    logic [REG_AW-1:0]     id_rs1_addr;
    logic [REG_AW-1:0]     id_rs2_addr;
    logic [REG_AW-1:0]     id_rd_addr;
    logic                  id_reg_write;
    logic [FUNC_WIDTH-1:0] id_alu_ctrl;
    logic                  id_mux1_ctrl;
    logic                  id_mux2_ctrl;

    logic                  mem_reg_write;
    logic [REG_AW-1:0]     mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  wb_reg_write;
    logic [REG_AW-1:0]     wb_rd_addr;
    logic [DATA_WIDTH-1:0] wb_data;

    logic                  ex_ready;
    logic                  ex_valid;
    logic [DATA_WIDTH-1:0] ex_pc;
    logic [DATA_WIDTH-1:0] ex_rs1;
    logic [DATA_WIDTH-1:0] ex_rs2;
    logic [DATA_WIDTH-1:0] ex_imm;
    logic [FUNC_WIDTH-1:0] ex_alu_ctrl;
    logic                  ex_mux1_ctrl;
    logic                  ex_mux2_ctrl;
    logic                  ex_reg_write;
    logic [REG_AW-1:0]     ex_rd_addr;
    logic [REG_AW-1:0]     ex_rs1_addr;
    logic [REG_AW-1:0]     ex_rs2_addr;

    modport slave (
        input  id_valid, flush, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_reg_write,
               id_alu_ctrl, id_mux1_ctrl, id_mux2_ctrl,
               mem_reg_write, mem_rd_addr, mem_data,
               wb_reg_write, wb_rd_addr, wb_data, ex_ready,
        output id_ready, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_imm, ex_alu_ctrl,
               ex_mux1_ctrl, ex_mux2_ctrl, ex_reg_write, ex_rd_addr,
               ex_rs1_addr, ex_rs2_addr
    );

    modport master (
        output id_valid, flush, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_reg_write,
               id_alu_ctrl, id_mux1_ctrl, id_mux2_ctrl,
               mem_reg_write, mem_rd_addr, mem_data,
               wb_reg_write, wb_rd_addr, wb_data, ex_ready,
        input  id_ready, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_imm, ex_alu_ctrl,
               ex_mux1_ctrl, ex_mux2_ctrl, ex_reg_write, ex_rd_addr,
               ex_rs1_addr, ex_rs2_addr
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU; latency 1 cycle, full throughput on drain+accept.
// Backpressure: id_ready = !ex_valid | ex_ready; flush squashes held and incoming work.
// Define ID_EX_FWD_EN to bypass MEM/WB results into operands at capture and while stalled.
module id_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int FUNC_WIDTH = 5,
    parameter int REG_AW     = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);

    logic                  accept;
    logic [DATA_WIDTH-1:0] cap_rs1;
    logic [DATA_WIDTH-1:0] cap_rs2;
    logic [DATA_WIDTH-1:0] hold_rs1;
    logic [DATA_WIDTH-1:0] hold_rs2;

    assign bus.id_ready = !bus.ex_valid || bus.ex_ready;
    assign accept       = bus.id_valid && bus.id_ready && !bus.flush;

`ifdef ID_EX_FWD_EN
    // MEM is the younger producer, so it wins over WB; x0 is hardwired and never bypassed.
    function automatic logic [DATA_WIDTH-1:0] fwd_sel(
        input logic [REG_AW-1:0]     rs,
        input logic [DATA_WIDTH-1:0] src,
        input logic                  m_we,
        input logic [REG_AW-1:0]     m_rd,
        input logic [DATA_WIDTH-1:0] m_dat,
        input logic                  w_we,
        input logic [REG_AW-1:0]     w_rd,
        input logic [DATA_WIDTH-1:0] w_dat
    );
        logic [DATA_WIDTH-1:0] res;
        res = src;
        if (rs != '0) begin
            if (m_we && m_rd == rs)
                res = m_dat;
            else if (w_we && w_rd == rs)
                res = w_dat;
        end
        return res;
    endfunction

    assign cap_rs1  = fwd_sel(bus.id_rs1_addr, bus.id_rs1_data,
                              bus.mem_reg_write, bus.mem_rd_addr, bus.mem_data,
                              bus.wb_reg_write, bus.wb_rd_addr, bus.wb_data);
    assign cap_rs2  = fwd_sel(bus.id_rs2_addr, bus.id_rs2_data,
                              bus.mem_reg_write, bus.mem_rd_addr, bus.mem_data,
                              bus.wb_reg_write, bus.wb_rd_addr, bus.wb_data);
    assign hold_rs1 = fwd_sel(bus.ex_rs1_addr, bus.ex_rs1,
                              bus.mem_reg_write, bus.mem_rd_addr, bus.mem_data,
                              bus.wb_reg_write, bus.wb_rd_addr, bus.wb_data);
    assign hold_rs2 = fwd_sel(bus.ex_rs2_addr, bus.ex_rs2,
                              bus.mem_reg_write, bus.mem_rd_addr, bus.mem_data,
                              bus.wb_reg_write, bus.wb_rd_addr, bus.wb_data);
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.mem_reg_write, bus.mem_rd_addr, bus.mem_data,
                          bus.wb_reg_write, bus.wb_rd_addr, bus.wb_data};
    assign cap_rs1  = bus.id_rs1_data;
    assign cap_rs2  = bus.id_rs2_data;
    assign hold_rs1 = bus.ex_rs1;
    assign hold_rs2 = bus.ex_rs2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_pc        <= '0;
            bus.ex_rs1       <= '0;
            bus.ex_rs2       <= '0;
            bus.ex_imm       <= '0;
            bus.ex_alu_ctrl  <= '0;
            bus.ex_mux1_ctrl <= 1'b0;
            bus.ex_mux2_ctrl <= 1'b0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_rd_addr   <= '0;
            bus.ex_rs1_addr  <= '0;
            bus.ex_rs2_addr  <= '0;
        end else if (bus.flush) begin
            // Clearing reg_write too keeps a squashed slot from looking like a producer.
            bus.ex_valid     <= 1'b0;
            bus.ex_reg_write <= 1'b0;
        end else if (accept) begin
            bus.ex_valid     <= 1'b1;
            bus.ex_pc        <= bus.id_pc;
            bus.ex_rs1       <= cap_rs1;
            bus.ex_rs2       <= cap_rs2;
            bus.ex_imm       <= bus.id_imm;
            bus.ex_alu_ctrl  <= bus.id_alu_ctrl;
            bus.ex_mux1_ctrl <= bus.id_mux1_ctrl;
            bus.ex_mux2_ctrl <= bus.id_mux2_ctrl;
            bus.ex_reg_write <= bus.id_reg_write;
            bus.ex_rd_addr   <= bus.id_rd_addr;
            bus.ex_rs1_addr  <= bus.id_rs1_addr;
            bus.ex_rs2_addr  <= bus.id_rs2_addr;
        end else if (bus.ex_valid && bus.ex_ready) begin
            bus.ex_valid <= 1'b0;
        end else if (bus.ex_valid) begin
            bus.ex_rs1 <= hold_rs1;
            bus.ex_rs2 <= hold_rs2;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage; build with or without ID_EX_FWD_EN.
module tb_id_ex_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic        m1;
        logic        m2;
        logic        rw;
        logic [4:0]  rd;
        logic [4:0]  a1;
        logic [4:0]  a2;
    } rec_t;

    typedef struct packed {
        logic        mw;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wd;
    } fw_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();
    id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    rec_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    bit   held = 1'b0;
    bit   exp_ready = 1'b1;
    bit   rw_zero = 1'b0;

    task automatic chk(input string nm, input logic [150:0] act, input logic [150:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic rec_t get_out();
        rec_t r;
        r.pc  = bus.ex_pc;        r.rs1 = bus.ex_rs1;       r.rs2 = bus.ex_rs2;
        r.imm = bus.ex_imm;       r.alu = bus.ex_alu_ctrl;  r.m1  = bus.ex_mux1_ctrl;
        r.m2  = bus.ex_mux2_ctrl; r.rw  = bus.ex_reg_write; r.rd  = bus.ex_rd_addr;
        r.a1  = bus.ex_rs1_addr;  r.a2  = bus.ex_rs2_addr;
        return r;
    endfunction

    // Architectural value seen by the ALU: newest in-flight write to that register, else source.
    function automatic logic [31:0] pick(input logic [4:0] a, input logic [31:0] src, input fw_t f);
`ifdef ID_EX_FWD_EN
        if (a != 0 && f.mw && f.mrd == a) return f.md;
        if (a != 0 && f.ww && f.wrd == a) return f.wd;
`endif
        return src;
    endfunction

    function automatic rec_t rnd_rec();
        rec_t r;
        r.pc = $urandom; r.rs1 = $urandom; r.rs2 = $urandom; r.imm = $urandom;
        r.alu = 5'($urandom); r.m1 = 1'($urandom); r.m2 = 1'($urandom); r.rw = 1'($urandom);
        r.rd = 5'($urandom_range(0, 7)); r.a1 = 5'($urandom_range(0, 7));
        r.a2 = 5'($urandom_range(0, 7));
        return r;
    endfunction

    function automatic fw_t rnd_fw();
        fw_t f;
        f.mw = 1'($urandom); f.mrd = 5'($urandom_range(0, 7)); f.md = $urandom;
        f.ww = 1'($urandom); f.wrd = 5'($urandom_range(0, 7)); f.wd = $urandom;
        return f;
    endfunction

    task automatic drive(input logic iv, input logic er, input logic fl, input rec_t d, input fw_t f);
        bus.id_valid = iv; bus.ex_ready = er; bus.flush = fl;
        bus.id_pc = d.pc; bus.id_rs1_data = d.rs1; bus.id_rs2_data = d.rs2; bus.id_imm = d.imm;
        bus.id_alu_ctrl = d.alu; bus.id_mux1_ctrl = d.m1; bus.id_mux2_ctrl = d.m2;
        bus.id_reg_write = d.rw; bus.id_rd_addr = d.rd;
        bus.id_rs1_addr = d.a1; bus.id_rs2_addr = d.a2;
        bus.mem_reg_write = f.mw; bus.mem_rd_addr = f.mrd; bus.mem_data = f.md;
        bus.wb_reg_write = f.ww; bus.wb_rd_addr = f.wrd; bus.wb_data = f.wd;
    endtask

    // One clock cycle: apply inputs after the edge, then update the model once the monitor has sampled.
    task automatic cyc(input logic iv, input logic er, input logic fl, input rec_t d, input fw_t f);
        rec_t e;
        @(posedge clk);
        #1 drive(iv, er, fl, d, f);
        @(negedge clk);
        #2;
        if (fl) begin
            if (held) void'(q.pop_front());
            rw_zero = 1'b1;
        end else begin
            if (held) begin
                q[0].rs1 = pick(q[0].a1, q[0].rs1, f);
                q[0].rs2 = pick(q[0].a2, q[0].rs2, f);
            end
            if (iv && exp_ready) begin
                e = d;
                e.rs1 = pick(d.a1, d.rs1, f);
                e.rs2 = pick(d.a2, d.rs2, f);
                q.push_back(e);
                rw_zero = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            exp_ready = (q.size() == 0) || bus.ex_ready;
            held      = (q.size() != 0) && !bus.ex_ready;
            chk("id_ready", 151'(bus.id_ready), 151'(exp_ready));
            chk("ex_valid", 151'(bus.ex_valid), 151'(q.size() != 0));
            if (q.size() != 0) begin
                chk("ex_fields", get_out(), q[0]);
                if (bus.ex_ready) void'(q.pop_front());
            end else if (rw_zero) begin
                chk("flush_reg_write", 151'(bus.ex_reg_write), 151'(0));
            end
        end
    end

    initial begin
        rec_t r;
        fw_t  f0;
        fw_t  f;
        f0 = '0;
        r  = '0;
        drive(1'b0, 1'b1, 1'b0, r, f0);
        #3;
        chk("reset_outputs", get_out(), '0);
        chk("reset_ex_valid", 151'(bus.ex_valid), 151'(0));
        chk("reset_id_ready", 151'(bus.id_ready), 151'(1));
        #5 rst_n = 1'b1;
        mon_en = 1'b1;

        // Basic accept
        r = '0; r.pc = 32'h100; r.rs1 = 32'h5; r.alu = 5'h3; r.a1 = 5'd1;
        cyc(1'b1, 1'b1, 1'b0, r, f0);
        // Stall three cycles with new work offered, then release
        cyc(1'b1, 1'b0, 1'b0, rnd_rec(), f0);
        cyc(1'b1, 1'b0, 1'b0, rnd_rec(), f0);
        cyc(1'b1, 1'b0, 1'b0, rnd_rec(), f0);
        r = rnd_rec(); r.rw = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, r, f0);
        // Flush while full and stalled, then flush with empty stage and a valid incoming op
        cyc(1'b1, 1'b0, 1'b1, rnd_rec(), f0);
        r = rnd_rec(); r.rw = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, r, f0);
        cyc(1'b0, 1'b1, 1'b0, r, f0);

        // Bypass priority on rs1=7
        r = rnd_rec(); r.a1 = 5'd7;
        f = '{mw: 1'b1, mrd: 5'd7, md: 32'hAA, ww: 1'b1, wrd: 5'd7, wd: 32'hBB};
        cyc(1'b1, 1'b1, 1'b0, r, f);
        f.mrd = 5'd0;
        cyc(1'b1, 1'b1, 1'b0, r, f);
        // Hold refresh on rs2=9, then x0 operand under an x0 write
        r = rnd_rec(); r.a2 = 5'd9;
        cyc(1'b1, 1'b1, 1'b0, r, f0);
        f = '{mw: 1'b0, mrd: 5'd0, md: 32'h0, ww: 1'b1, wrd: 5'd9, wd: 32'h1234};
        cyc(1'b0, 1'b0, 1'b0, r, f);
        r = rnd_rec(); r.a1 = 5'd0; r.rs1 = 32'h0;
        cyc(1'b1, 1'b1, 1'b0, r, f0);
        f = '{mw: 1'b1, mrd: 5'd0, md: 32'hDEAD, ww: 1'b1, wrd: 5'd0, wd: 32'hBEEF};
        cyc(1'b0, 1'b0, 1'b0, r, f);
        cyc(1'b0, 1'b1, 1'b0, r, f0);

        // Asynchronous reset while holding a valid instruction
        cyc(1'b1, 1'b0, 1'b0, rnd_rec(), f0);
        cyc(1'b0, 1'b0, 1'b0, rnd_rec(), f0);
        drive(1'b0, 1'b0, 1'b0, '0, f0);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", get_out(), '0);
        chk("midreset_ex_valid", 151'(bus.ex_valid), 151'(0));
        chk("midreset_id_ready", 151'(bus.id_ready), 151'(1));
        q.delete();
        rw_zero = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                rnd_rec(), rnd_fw());
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, '0, f0);
        chk("final_drain", 151'(q.size()), 151'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
